// File: rtl/spi_pkg.sv
// spi_pkg: state encoding and elaboration helpers shared by the SPI bit engines
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_FETCH = 3'd2,
        ST_WAIT  = 3'd3,
        ST_LOW   = 3'd4,
        ST_HIGH  = 3'd5,
        ST_HOLD  = 3'd6
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((32'sd1 <<< i) < v) r = i + 1;
        return r;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/spi_phase_cnt.sv
// spi_phase_cnt: loadable down-counter; tc_o is high once the count reaches zero
module spi_phase_cnt #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else if (load_i) cnt_q <= val_i;
        else if (cnt_q != '0) cnt_q <= cnt_q - W'(1);
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/spi_bit_tx.sv
// spi_bit_tx: SPI mode-0 master bit engine pulling one MOSI bit per SCLK period from a FIFO
module spi_bit_tx
    import spi_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int LSIZE    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LSIZE-1:0] bit_len,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic             fifo_rd_en,
    input  logic             fifo_rd_data,
    input  logic             fifo_rd_vld,
    input  logic             fifo_empty,
    output logic             spi_cs_n,
    output logic             spi_sclk,
    output logic             spi_mosi,
    input  logic             spi_miso,
    output logic             rx_bit,
    output logic             rx_vld
);

    localparam int PW = clog2(max3(CLK_DIV, CS_SETUP, CS_HOLD) + 1);

    state_e           state_q, state_d;
    logic [LSIZE-1:0] rem_q, rem_d;
    logic             cs_n_q, cs_n_d, sclk_q, sclk_d, mosi_q, mosi_d;
    logic             busy_q, busy_d, done_q, done_d, stall_q, stall_d;
    logic             rd_en_q, rd_en_d, rx_bit_q, rx_bit_d, rx_vld_q, rx_vld_d;
    logic             ph_load, ph_tc;
    logic [PW-1:0]    ph_val;

    spi_phase_cnt #(.W(PW)) u_phase (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (ph_load),
        .val_i  (ph_val),
        .tc_o   (ph_tc)
    );

    // Every path into FETCH issues the read immediately so the FIFO latency overlaps the low phase.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        cs_n_d   = cs_n_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        busy_d   = busy_q;
        stall_d  = stall_q;
        rx_bit_d = rx_bit_q;
        done_d   = 1'b0;
        rd_en_d  = 1'b0;
        rx_vld_d = 1'b0;
        ph_load  = 1'b0;
        ph_val   = '0;
        case (state_q)
            ST_IDLE: if (start && !done_q) begin
                if (bit_len == '0) done_d = 1'b1;
                else begin
                    state_d = ST_SETUP;
                    rem_d   = bit_len;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    ph_load = 1'b1;
                    ph_val  = PW'(CS_SETUP - 1);
                end
            end
            ST_SETUP: if (ph_tc) begin
                state_d = ST_FETCH;
                rd_en_d = !fifo_empty;
                stall_d = fifo_empty;
            end
            ST_FETCH: if (!rd_en_q) begin
                rd_en_d = !fifo_empty;
                stall_d = fifo_empty;
            end else state_d = ST_WAIT;
            ST_WAIT: if (fifo_rd_vld) begin
                state_d = ST_LOW;
                mosi_d  = fifo_rd_data;
                ph_load = 1'b1;
                ph_val  = PW'(CLK_DIV - 1);
            end else begin
                state_d = ST_FETCH;
                rd_en_d = !fifo_empty;
                stall_d = fifo_empty;
            end
            ST_LOW: if (ph_tc) begin
                state_d  = ST_HIGH;
                sclk_d   = 1'b1;
                rx_bit_d = spi_miso;
                rx_vld_d = 1'b1;
                rem_d    = rem_q - LSIZE'(1);
                ph_load  = 1'b1;
                ph_val   = PW'(CLK_DIV - 1);
            end
            ST_HIGH: if (ph_tc) begin
                sclk_d = 1'b0;
                if (rem_q != '0) begin
                    state_d = ST_FETCH;
                    rd_en_d = !fifo_empty;
                    stall_d = fifo_empty;
                end else begin
                    state_d = ST_HOLD;
                    ph_load = 1'b1;
                    ph_val  = PW'(CS_HOLD - 1);
                end
            end
            ST_HOLD: if (ph_tc) begin
                state_d  = ST_IDLE;
                cs_n_d   = 1'b1;
                busy_d   = 1'b0;
                done_d   = 1'b1;
                mosi_d   = 1'b0;
                rx_bit_d = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rem_q    <= '0;
            cs_n_q   <= 1'b1;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            stall_q  <= 1'b0;
            rd_en_q  <= 1'b0;
            rx_bit_q <= 1'b0;
            rx_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            cs_n_q   <= cs_n_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            stall_q  <= stall_d;
            rd_en_q  <= rd_en_d;
            rx_bit_q <= rx_bit_d;
            rx_vld_q <= rx_vld_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign stall      = stall_q;
    assign fifo_rd_en = rd_en_q;
    assign spi_cs_n   = cs_n_q;
    assign spi_sclk   = sclk_q;
    assign spi_mosi   = mosi_q;
    assign rx_bit     = rx_bit_q;
    assign rx_vld     = rx_vld_q;

endmodule

// File: tb/tb_spi_bit_tx.sv
// tb_spi_bit_tx: directed bench for spi_bit_tx with a behavioural 1-bit FIFO and SPI monitor
module tb_spi_bit_tx;

    logic        clk = 1'b0;
    logic        rst_n, start, loop;
    logic [15:0] bit_len;
    logic        busy, done, stall, fifo_rd_en, fifo_rd_data, spi_cs_n, spi_sclk, spi_mosi, spi_miso;
    logic        rx_bit, rx_vld;
    logic        fifo_rd_vld = 1'b0;
    logic        fifo_empty = 1'b1;
    logic        push_en, push_bit;
    logic        fq[$];
    logic [8:0]  outs;

    always #5 clk = ~clk;

    spi_bit_tx #(.CLK_DIV(2), .CS_SETUP(2), .CS_HOLD(2), .LSIZE(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .bit_len      (bit_len),
        .busy         (busy),
        .done         (done),
        .stall        (stall),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_vld  (fifo_rd_vld),
        .fifo_empty   (fifo_empty),
        .spi_cs_n     (spi_cs_n),
        .spi_sclk     (spi_sclk),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .rx_bit       (rx_bit),
        .rx_vld       (rx_vld)
    );

    assign spi_miso = loop ? spi_mosi : ~spi_mosi;
    assign outs = {spi_cs_n, spi_sclk, spi_mosi, busy, done, stall, fifo_rd_en, rx_bit, rx_vld};

    // FIFO with one-cycle read latency and a registered empty flag; unaffected by DUT reset.
    always @(posedge clk) begin
        if (fifo_rd_en && fq.size() != 0) begin
            fifo_rd_vld  <= 1'b1;
            fifo_rd_data <= fq.pop_front();
        end else fifo_rd_vld <= 1'b0;
        if (push_en) fq.push_back(push_bit);
        fifo_empty <= (fq.size() == 0);
    end

    int cyc = 0, n_rise = 0, n_rd = 0, n_vld = 0, n_done = 0, n_viol = 0;
    int t_cs_fall = 0, t_first_rd = 0, t_last_fall = 0, t_cs_rise = 0;
    logic first_pend = 1'b0, p_sclk = 1'b0, p_mosi = 1'b0, p_cs = 1'b1;
    logic [15:0] mosi_sh = '0, rx_sh = '0;

    always @(negedge clk) begin
        cyc    <= cyc + 1;
        p_sclk <= spi_sclk;
        p_mosi <= spi_mosi;
        p_cs   <= spi_cs_n;
        if (spi_sclk && !p_sclk) begin
            n_rise  <= n_rise + 1;
            mosi_sh <= {mosi_sh[14:0], spi_mosi};
        end
        if (!spi_sclk && p_sclk) t_last_fall <= cyc;
        if (fifo_rd_en) n_rd <= n_rd + 1;
        if (fifo_rd_en && first_pend) begin
            t_first_rd <= cyc;
            first_pend <= 1'b0;
        end
        if (rx_vld) begin
            n_vld <= n_vld + 1;
            rx_sh <= {rx_sh[14:0], rx_bit};
        end
        if (done) n_done <= n_done + 1;
        if (!spi_cs_n && p_cs) begin
            t_cs_fall  <= cyc;
            first_pend <= 1'b1;
        end
        if (spi_cs_n && !p_cs) t_cs_rise <= cyc;
        if (spi_sclk && p_sclk && spi_mosi !== p_mosi) n_viol <= n_viol + 1;
    end

    int n_cmp = 0, n_bad = 0;
    int b_rise, b_rd, b_vld, b_done, t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push_bits(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            push_en  = 1'b1;
            push_bit = v[i];
            @(negedge clk);
        end
        push_en = 1'b0;
    endtask

    task automatic snap();
        b_rise = n_rise;
        b_rd   = n_rd;
        b_vld  = n_vld;
        b_done = n_done;
    endtask

    task automatic kick(input logic [15:0] len);
        start   = 1'b1;
        bit_len = len;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int lim);
        int k;
        k = 0;
        while (!done && k < lim) begin
            @(negedge clk);
            k++;
        end
        check(nm, done, 1);
    endtask

    typedef struct {
        int          len;
        logic [15:0] data;
        logic        loop;
        logic [15:0] exp_rx;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] m;
        vecs[0] = '{len: 8,  data: 16'h00A5, loop: 1'b0, exp_rx: 16'h005A};
        vecs[1] = '{len: 8,  data: 16'h003C, loop: 1'b1, exp_rx: 16'h003C};
        vecs[2] = '{len: 4,  data: 16'h0009, loop: 1'b0, exp_rx: 16'h0006};
        vecs[3] = '{len: 1,  data: 16'h0001, loop: 1'b1, exp_rx: 16'h0001};
        vecs[4] = '{len: 16, data: 16'hBEEF, loop: 1'b0, exp_rx: 16'h4110};
        rst_n = 1'b0; start = 1'b1; bit_len = 16'd8; push_en = 1'b0; push_bit = 1'b0; loop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rst_cycle%0d", i), outs, 9'h100);
        end
        check("rst_no_rd", n_rd, 0);
        rst_n = 1'b1; start = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            loop = vecs[i].loop;
            m = 16'((32'd1 << vecs[i].len) - 1);
            push_bits(vecs[i].data, vecs[i].len);
            snap();
            kick(16'(vecs[i].len));
            wait_done($sformatf("v%0d_done", i), 400);
            repeat (3) @(negedge clk);
            check($sformatf("v%0d_edges", i), n_rise - b_rise, vecs[i].len);
            check($sformatf("v%0d_rd", i), n_rd - b_rd, vecs[i].len);
            check($sformatf("v%0d_rxvld", i), n_vld - b_vld, vecs[i].len);
            check($sformatf("v%0d_ndone", i), n_done - b_done, 1);
            check($sformatf("v%0d_mosi", i), mosi_sh & m, vecs[i].data & m);
            check($sformatf("v%0d_rx", i), rx_sh & m, vecs[i].exp_rx & m);
            check($sformatf("v%0d_setup", i), t_first_rd - t_cs_fall, 2);
            check($sformatf("v%0d_hold", i), t_cs_rise - t_last_fall, 2);
            check($sformatf("v%0d_idle", i), outs, 9'h100);
        end

        // FIFO runs dry after 3 of 5 bits
        loop = 1'b0;
        push_bits(16'b101, 3);
        snap();
        kick(16'd5);
        t = 0;
        while (!stall && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("t3_stall", stall, 1);
        check("t3_sclk", spi_sclk, 0);
        check("t3_cs", spi_cs_n, 0);
        repeat (10) @(negedge clk);
        check("t3_edges3", n_rise - b_rise, 3);
        check("t3_still", {stall, busy, spi_sclk}, 3'b110);
        push_bits(16'b11, 2);
        wait_done("t3_done", 300);
        repeat (3) @(negedge clk);
        check("t3_edges5", n_rise - b_rise, 5);
        check("t3_rd", n_rd - b_rd, 5);
        check("t3_mosi", mosi_sh[4:0], 5'h17);
        check("t3_ndone", n_done - b_done, 1);

        // zero length, start while busy, start on the done cycle
        snap();
        kick(16'd0);
        check("t5_zero_done", {done, spi_cs_n, busy}, 3'b110);
        @(negedge clk);
        check("t5_zero_pulse", done, 0);
        check("t5_zero_edges", n_rise - b_rise, 0);
        push_bits(16'hD, 4);
        snap();
        kick(16'd4);
        repeat (8) @(negedge clk);
        check("t5_busy", busy, 1);
        kick(16'd8);
        wait_done("t5_done", 200);
        start = 1'b1; bit_len = 16'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        check("t5_idle", {busy, spi_cs_n}, 2'b01);
        check("t5_edges", n_rise - b_rise, 4);
        check("t5_ndone", n_done - b_done, 1);
        check("t5_mosi", mosi_sh[3:0], 4'hD);

        // reset after the third rising edge, then resume from the FIFO
        push_bits(16'hC6, 8);
        snap();
        kick(16'd8);
        t = 0;
        while (n_rise - b_rise < 3 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("t6_edges3", n_rise - b_rise, 3);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t6_rst", outs, 9'h100);
        @(negedge clk);
        check("t6_rd3", n_rd - b_rd, 3);
        snap();
        kick(16'd2);
        wait_done("t6_done2", 200);
        repeat (3) @(negedge clk);
        check("t6_edges2", n_rise - b_rise, 2);
        check("t6_mosi2", mosi_sh[1:0], 2'b00);
        snap();
        kick(16'd3);
        wait_done("t6_done3", 200);
        repeat (3) @(negedge clk);
        check("t6_edges_tail", n_rise - b_rise, 3);
        check("t6_mosi_tail", mosi_sh[2:0], 3'b110);
        check("mosi_stable", n_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
